proc_core: RTL and testbench

//  Single-cycle 16-bit load/store processor core with separate instruction and data ports.

---
 rtl/proc_pkg.sv | 40 ++++
 rtl/proc_if.sv | 13 +
 rtl/proc_alu.sv | 33 +++
 rtl/proc_core.sv | 92 +++++++++
 tb/tb_proc_core.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared constants and types for the proc_core slice: field positions, opcode classes, ALU ops, flags.
package proc_pkg;
  localparam int WORD_W = 16;
  localparam int NREG   = 8;
  localparam int REG_AW = 3;

  localparam int CLS_HI = 15, CLS_LO = 14;
  localparam int FN_HI  = 13, FN_LO  = 11;
  localparam int RD_HI  = 10, RD_LO  = 8;
  localparam int RS_HI  = 7,  RS_LO  = 5;
  localparam int IMM_HI = 7,  IMM_LO = 0;

  typedef enum logic [1:0] {
    CLS_ALU_R = 2'b00,
    CLS_ALU_I = 2'b01,
    CLS_MEM   = 2'b10,
    CLS_CTL   = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR  = 3'd3,
    ALU_XOR = 3'd4, ALU_SHL = 3'd5, ALU_SHR = 3'd6, ALU_MOV = 3'd7
  } alu_op_e;

  localparam logic [2:0] MEM_LD  = 3'd0;
  localparam logic [2:0] MEM_ST  = 3'd1;
  localparam logic [2:0] MEM_MUL = 3'd2;

  localparam logic [2:0] CTL_JMP = 3'd0;
  localparam logic [2:0] CTL_JZ  = 3'd1;
  localparam logic [2:0] CTL_JC  = 3'd2;
  localparam logic [2:0] CTL_JS  = 3'd3;
  localparam logic [2:0] CTL_BR  = 3'd4;

  typedef struct packed {
    logic c;
    logic s;
    logic z;
  } flags_t;
endpackage

// File: rtl/proc_if.sv
// Instruction/data bus between proc_core (master) and the external memories (slave).
interface proc_if;
  import proc_pkg::*;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] inst;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_in;
  logic [WORD_W-1:0] mem_out;
  logic              we;

  modport master (output pc, mem_addr, mem_out, we, input inst, mem_in);
  modport slave  (input pc, mem_addr, mem_out, we, output inst, mem_in);
endinterface

// File: rtl/proc_alu.sv
// Combinational ALU: operand0 (rd) OP operand1 (rs or imm) with carry/sign/zero flags.
module proc_alu
  import proc_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  alu_op_e           op,
  output logic [WORD_W-1:0] y,
  output flags_t            fl
);
  logic [WORD_W:0] ext;
  logic            c;

  always_comb begin
    ext = '0;
    y   = '0;
    c   = 1'b0;
    case (op)
      ALU_ADD: begin ext = {1'b0, a} + {1'b0, b}; y = ext[WORD_W-1:0]; c = ext[WORD_W]; end
      // borrow is exactly the unsigned a<b case
      ALU_SUB: begin y = a - b; c = (a < b); end
      ALU_AND: y = a & b;
      ALU_OR : y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SHL: begin y = {a[WORD_W-2:0], 1'b0}; c = a[WORD_W-1]; end
      ALU_SHR: begin y = {1'b0, a[WORD_W-1:1]}; c = a[0]; end
      ALU_MOV: y = b;
      default: y = '0;
    endcase
  end

  assign fl = '{c: c, s: y[WORD_W-1], z: (y == '0)};
endmodule

// File: rtl/proc_core.sv
// Single-cycle 16-bit load/store core: decode, register file, writeback and pc update.
// Optional MUL in the class-10 func-010 slot when PROC_MUL_EN is defined.
module proc_core
  import proc_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  proc_if.master bus
);
`ifdef PROC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic [WORD_W-1:0]   rf [NREG];
  logic [WORD_W-1:0]   pc_q, pc_nx, opa, opb, rs_v, alu_y, rf_wd;
  logic [2*WORD_W-1:0] prod;
  flags_t              fl_q, fl_d, alu_fl;
  logic                rf_we, fl_we;
  cls_e                cls;
  logic [2:0]          fn;
  logic [REG_AW-1:0]   rd, rs;
  logic [7:0]          imm;

  assign cls  = cls_e'(bus.inst[CLS_HI:CLS_LO]);
  assign fn   = bus.inst[FN_HI:FN_LO];
  assign rd   = bus.inst[RD_HI:RD_LO];
  assign rs   = bus.inst[RS_HI:RS_LO];
  assign imm  = bus.inst[IMM_HI:IMM_LO];

  assign opa  = rf[rd];
  assign rs_v = rf[rs];
  assign opb  = (cls == CLS_ALU_R) ? rs_v : {{(WORD_W-8){1'b0}}, imm};
  assign prod = {{WORD_W{1'b0}}, opa} * {{WORD_W{1'b0}}, rs_v};

  proc_alu u_alu (.a(opa), .b(opb), .op(alu_op_e'(fn)), .y(alu_y), .fl(alu_fl));

  assign bus.pc       = pc_q;
  assign bus.mem_addr = rs_v;
  assign bus.mem_out  = opa;
  // gated by rst so an in-flight store is dropped the moment reset asserts
  assign bus.we       = rst && (cls == CLS_MEM) && (fn == MEM_ST);

  always_comb begin
    rf_we = 1'b0;
    fl_we = 1'b0;
    rf_wd = alu_y;
    fl_d  = alu_fl;
    case (cls)
      CLS_ALU_R, CLS_ALU_I: begin rf_we = 1'b1; fl_we = 1'b1; end
      CLS_MEM: begin
        if (fn == MEM_LD) begin
          rf_we = 1'b1;
          rf_wd = bus.mem_in;
        end else if (MUL_EN && fn == MEM_MUL) begin
          rf_we = 1'b1;
          fl_we = 1'b1;
          rf_wd = prod[WORD_W-1:0];
          fl_d  = '{c: |prod[2*WORD_W-1:WORD_W], s: prod[WORD_W-1], z: (prod[WORD_W-1:0] == '0)};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_nx = pc_q + WORD_W'(1);
    if (cls == CLS_CTL) begin
      case (fn)
        CTL_JMP: pc_nx = rs_v;
        CTL_JZ : if (fl_q.z) pc_nx = rs_v;
        CTL_JC : if (fl_q.c) pc_nx = rs_v;
        CTL_JS : if (fl_q.s) pc_nx = rs_v;
        CTL_BR : pc_nx = pc_q + {{(WORD_W-8){imm[7]}}, imm};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= '0;
      fl_q <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      pc_q <= pc_nx;
      if (fl_we) fl_q <= fl_d;
      if (rf_we) rf[rd] <= rf_wd;
    end
  end
endmodule

// File: tb/tb_proc_core.sv
// Directed + random bench for proc_core against an instruction-level reference model.
module tb_proc_core;
  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  SHL = 5'd5;
  localparam logic [4:0] ADDI = 5'd8, ORI = 5'd11, MOVI = 5'd15;
  localparam logic [4:0] LD = 5'd16, ST = 5'd17, MUL = 5'd18, NOP = 5'd19;
  localparam logic [4:0] JMP = 5'd24, JZ = 5'd25, JC = 5'd26, JS = 5'd27, BR = 5'd28;

  logic clk, rst;
  int   checks, failures;
  logic [15:0] dmem [0:65535];
  logic [15:0] last_out, last_addr;
  logic        last_we;

  // reference model state
  logic [15:0] mr [8];
  logic [15:0] mpc;
  logic        mc, ms, mz;
  logic [15:0] mmem [int];

  proc_if bus ();
  proc_core dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_in = dmem[bus.mem_addr];
  always @(posedge clk) if (rst && bus.we) dmem[bus.mem_addr] <= bus.mem_out;

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rd, input logic [7:0] lo);
    return {op, rd, lo};
  endfunction

  function automatic logic [15:0] encr(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs);
    return {op, rd, rs, 5'b0};
  endfunction

  function automatic logic [15:0] mread(input int a);
    logic [15:0] av;
    av = a[15:0];
    return mmem.exists(a) ? mmem[a] : (av ^ 16'hA5A5);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) mr[k] = '0;
    mpc = '0; mc = 0; ms = 0; mz = 0;
  endtask

  task automatic model_exec(input logic [15:0] i);
    int op, cls, fn, rd, rs, imm, a, b, r, npc, sx;
    longint p;
    bit c;
    op  = int'(i[15:11]); cls = op / 8; fn = op % 8;
    rd  = int'(i[10:8]); rs = int'(i[7:5]); imm = int'(i[7:0]);
    a   = int'(mr[rd]);
    b   = (cls == 0) ? int'(mr[rs]) : imm;
    npc = (int'(mpc) + 1) % 65536;
    r = 0; c = 0;
    if (cls < 2) begin
      case (fn)
        0: begin r = a + b; c = (r > 65535); end
        1: begin r = a - b + 65536; c = (a < b); end
        2: r = a & b;
        3: r = a | b;
        4: r = a ^ b;
        5: begin r = a * 2; c = (a >= 32768); end
        6: begin r = a / 2; c = (a % 2) == 1; end
        default: r = b;
      endcase
      r = r % 65536;
      mr[rd] = r[15:0]; mz = (r == 0); ms = (r >= 32768); mc = c;
    end else if (cls == 2) begin
      if (fn == 0) mr[rd] = mread(int'(mr[rs]));
      else if (fn == 1) mmem[int'(mr[rs])] = mr[rd];
`ifdef PROC_MUL_EN
      else if (fn == 2) begin
        p = longint'(a) * longint'(mr[rs]);
        r = int'(p % 65536);
        mr[rd] = r[15:0]; mz = (r == 0); ms = (r >= 32768); mc = (p >= 65536);
      end
`endif
    end else begin
      sx = (imm >= 128) ? imm - 256 : imm;
      case (fn)
        0: npc = int'(mr[rs]);
        1: if (mz) npc = int'(mr[rs]);
        2: if (mc) npc = int'(mr[rs]);
        3: if (ms) npc = int'(mr[rs]);
        4: npc = (int'(mpc) + sx + 65536) % 65536;
        default: ;
      endcase
    end
    mpc = npc[15:0];
  endtask

  // Entered just after a rising edge; checks outputs mid-cycle, then clocks one instruction.
  task automatic step(input logic [15:0] i);
    bus.inst = i;
    @(negedge clk);
    last_out = bus.mem_out; last_addr = bus.mem_addr; last_we = bus.we;
    chk("pc", bus.pc, mpc);
    chk("we", {15'b0, bus.we}, {15'b0, (i[15:11] == ST) && rst});
    chk("mem_addr", bus.mem_addr, mr[i[7:5]]);
    chk("mem_out", bus.mem_out, mr[i[10:8]]);
    model_exec(i);
    @(posedge clk); #1;
  endtask

  task automatic peek(input logic [2:0] r, input logic [15:0] exp);
    step(enc(NOP, r, 8'h00));
    chk($sformatf("r%0d", r), last_out, exp);
  endtask

  task automatic load_reg(input logic [2:0] r, input logic [15:0] v);
    step(enc(MOVI, r, v[15:8]));
    repeat (8) step(encr(SHL, r, 3'd0));
    step(enc(ORI, r, v[7:0]));
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int a = 0; a < 65536; a++) dmem[a] = a[15:0] ^ 16'hA5A5;
    model_reset();
    rst = 1'b0;
    bus.inst = encr(ST, 3'd1, 3'd2);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", bus.pc, 16'h0000);
    chk("rst_we", {15'b0, bus.we}, 16'h0000);
    rst = 1'b1;

    // pc steps from 0 on a NOP stream
    for (int k = 0; k < 3; k++) begin
      step(enc(NOP, 3'd0, 8'h00));
      chk("pc_step", bus.pc, 16'(k + 1));
    end

    // ADD overflow: C=1 Z=1 S=0, probed with conditional jumps through r7
    load_reg(3'd7, 16'h0040);
    load_reg(3'd1, 16'hFFFF);
    peek(3'd1, 16'hFFFF);
    step(enc(ADDI, 3'd1, 8'h01));
    peek(3'd1, 16'h0000);
    step(encr(JC, 3'd0, 3'd7)); chk("jc_taken", bus.pc, 16'h0040);
    step(encr(JS, 3'd0, 3'd7)); chk("js_not", bus.pc, 16'h0041);
    step(encr(JZ, 3'd0, 3'd7)); chk("jz_taken", bus.pc, 16'h0040);
    step(enc(ORI, 3'd2, 8'h01));
    step(encr(JZ, 3'd0, 3'd7)); chk("jz_not", bus.pc, 16'h0042);

    // SUB with borrow: 3-5
    load_reg(3'd2, 16'h0003);
    load_reg(3'd3, 16'h0005);
    step(encr(SUB, 3'd2, 3'd3));
    peek(3'd2, 16'hFFFE);
    step(encr(JC, 3'd0, 3'd7)); chk("sub_c", bus.pc, 16'h0040);
    step(encr(JS, 3'd0, 3'd7)); chk("sub_s", bus.pc, 16'h0040);
    step(encr(JZ, 3'd0, 3'd7)); chk("sub_z", bus.pc, 16'h0041);

    // store then load back
    load_reg(3'd4, 16'h1234);
    load_reg(3'd5, 16'h0100);
    step(encr(ST, 3'd4, 3'd5));
    chk("st_we", {15'b0, last_we}, 16'h0001);
    chk("st_addr", last_addr, 16'h0100);
    chk("st_data", last_out, 16'h1234);
    step(enc(NOP, 3'd0, 8'h00));
    chk("we_low", {15'b0, last_we}, 16'h0000);
    step(encr(LD, 3'd6, 3'd5));
    peek(3'd6, 16'h1234);

    // JMP then backward branch
    load_reg(3'd0, 16'h0010);
    step(encr(JMP, 3'd0, 3'd0)); chk("jmp", bus.pc, 16'h0010);
    step(enc(BR, 3'd0, 8'hFE));  chk("br_back", bus.pc, 16'h000E);

    // MUL slot
    load_reg(3'd1, 16'h0100);
    load_reg(3'd2, 16'h0100);
    step(encr(MUL, 3'd1, 3'd2));
`ifdef PROC_MUL_EN
    peek(3'd1, 16'h0000);
    step(encr(JC, 3'd0, 3'd7)); chk("mul_c", bus.pc, 16'h0040);
`else
    peek(3'd1, 16'h0100);
`endif

    // reset asserted mid-instruction: store dropped, state cleared
    bus.inst = encr(ST, 3'd4, 3'd5);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_we", {15'b0, bus.we}, 16'h0000);
    chk("midrst_pc", bus.pc, 16'h0000);
    @(posedge clk); #1;
    model_reset();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) peek(k[2:0], 16'h0000);

    // random instruction stream
    for (int n = 0; n < 600; n++) step(16'($urandom));
    for (int k = 0; k < 8; k++) step(enc(NOP, k[2:0], 8'h00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
